// File: rtl/herculesae_vx_aes_pkg.sv
// Shared FSM state type and round-count decoding for the AES round scheduler.
`timescale 1ns/1ps
package herculesae_vx_aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WHITEN = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } sched_state_t;

    localparam logic [1:0] NR_10 = 2'b00;
    localparam logic [1:0] NR_12 = 2'b01;
    localparam logic [1:0] NR_14 = 2'b10;

    // The unused code 2'b11 is folded onto 14 rounds.
    function automatic logic [3:0] nr_rounds(input logic [1:0] code);
        case (code)
            NR_10:   return 4'd10;
            NR_12:   return 4'd12;
            NR_14:   return 4'd14;
            default: return 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/herculesae_vx_aes_rrarb.sv
// Two-way round-robin arbiter; the pointer moves away from whoever was last granted.
`timescale 1ns/1ps
module herculesae_vx_aes_rrarb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (valid[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/herculesae_vx_aes_sched.sv
// Sequences one AES operation at a time through an external round datapath,
// fetching round keys by index and arbitrating between two requesters.
`timescale 1ns/1ps
module herculesae_vx_aes_sched
    import herculesae_vx_aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_dec,
    input  logic [1:0]   req0_nr,
    input  logic [127:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_dec,
    input  logic [1:0]   req1_nr,
    input  logic [127:0] req1_data,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    output logic         rk_id,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic         dp_valid,
    output logic         dp_dec,
    output logic         dp_last,
    output logic [127:0] dp_in,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data
);

    sched_state_t fsm;
    logic [3:0]   round;
    logic [3:0]   nr_q;
    logic         dec_q;
    logic         id_q;
    logic [127:0] state_q;

    logic [1:0]   grant;
    logic         accept;
    logic         in_round;

    herculesae_vx_aes_rrarb u_rrarb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Ready is also masked by reset so no handshake can appear while reset is held.
    assign req0_ready = reset_n && (fsm == S_IDLE) && grant[0];
    assign req1_ready = reset_n && (fsm == S_IDLE) && grant[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm     <= S_IDLE;
            round   <= 4'd0;
            nr_q    <= 4'd0;
            dec_q   <= 1'b0;
            id_q    <= 1'b0;
            state_q <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (accept) begin
                        id_q    <= grant[1];
                        dec_q   <= grant[1] ? req1_dec : req0_dec;
                        nr_q    <= nr_rounds(grant[1] ? req1_nr : req0_nr);
                        state_q <= grant[1] ? req1_data : req0_data;
                        round   <= 4'd0;
                        fsm     <= S_WHITEN;
                    end
                end
                S_WHITEN: begin
                    if (rk_valid) begin
                        state_q <= state_q ^ rk_data;
                        round   <= 4'd1;
                        fsm     <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (rk_valid) begin
                        state_q <= dp_out;
                        if (round == nr_q) begin
                            fsm <= S_DONE;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        fsm <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign in_round = (fsm == S_ROUND);
    assign rk_req   = (fsm == S_WHITEN) || in_round;
    assign rk_id    = id_q;

    // Decryption walks the key schedule backwards from key Nr down to key 0.
    always_comb begin
        rk_idx = 4'd0;
        if (fsm == S_WHITEN) begin
            rk_idx = dec_q ? nr_q : 4'd0;
        end else if (in_round) begin
            rk_idx = dec_q ? (nr_q - round) : round;
        end
    end

    assign dp_valid  = in_round && rk_valid;
    assign dp_dec    = dec_q;
    assign dp_last   = in_round && (round == nr_q);
    assign dp_in     = state_q;
    assign dp_key    = in_round ? rk_data : '0;

    assign rsp_valid = (fsm == S_DONE);
    assign rsp_id    = id_q;
    assign rsp_data  = (fsm == S_DONE) ? state_q : '0;

endmodule

// File: doc/herculesae_vx_aes_sched.md
HERCULESAE_VX_AES_SCHED -- requirements
Module: herculesae_vx_aes_sched

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all flops rise-edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports reqN_valid (N=0,1)  input  1  requester N offers an operation.
REQ-004 SHALL have ports reqN_ready  output  1  scheduler accepts requester N this cycle.
REQ-005 SHALL have ports reqN_dec  input  1  1=decrypt, 0=encrypt.
REQ-006 SHALL have ports reqN_nr  input  2  round count: 00=10, 01=12, 10=14, 11 treated as 14.
REQ-007 SHALL have ports reqN_data  input  128  input block.
REQ-008 SHALL have port rk_req  output  1  round-key fetch request.
REQ-009 SHALL have ports rk_idx (output 4, key index) and rk_id (output 1, owning requester).
REQ-010 SHALL have ports rk_valid (input 1) and rk_data (input 128): round key for current rk_idx.
REQ-011 SHALL have ports dp_valid, dp_dec, dp_last  output  1 each: drive the combinational round datapath; dp_last = final round, no (Inv)MixColumns.
REQ-012 SHALL have ports dp_in, dp_key (output 128) and dp_out (input 128): datapath result in the same cycle.
REQ-013 SHALL have ports rsp_valid (output 1), rsp_ready (input 1), rsp_id (output 1), rsp_data (output 128).

Function
REQ-014 SHALL implement FSM IDLE -> WHITEN -> ROUND -> DONE -> IDLE.
REQ-015 In IDLE, SHALL grant round-robin between valid requesters: the pointer favours req0 after reset and moves to the other requester after each grant; if only one is valid, that one is granted.
REQ-016 SHALL assert reqN_ready only in IDLE, only for the granted N; acceptance is reqN_valid & reqN_ready; on acceptance, SHALL latch dec, Nr, data and id, then go to WHITEN.
REQ-017 WHITEN: rk_req=1, rk_idx = 0 (encrypt) or Nr (decrypt); on rk_valid, SHALL set state = data ^ rk_data and round counter r=1, then go to ROUND; SHALL stall without limit while rk_valid=0.
REQ-018 ROUND: rk_req=1, rk_idx = r (encrypt) or Nr-r (decrypt); dp_valid = rk_valid, dp_in = state, dp_key = rk_data, dp_dec = latched dec, dp_last = (r==Nr).
REQ-019 On rk_valid in ROUND, SHALL capture dp_out into state; if r==Nr, go to DONE, otherwise r = r+1 (4-bit counter, never wraps).
REQ-020 DONE: rsp_valid=1 with rsp_data=state and rsp_id=latched id; SHALL hold all three stable until rsp_ready; on the handshake, SHALL go to IDLE.
REQ-021 Latency with rk_valid held high: acceptance in cycle T gives rsp_valid in cycle T+2+Nr (Nr=10 gives T+12).
REQ-022 A request arriving while busy SHALL NOT be accepted; reqN_data/dec/nr changes after acceptance SHALL have no effect.
REQ-023 SHALL keep rk_req, dp_valid, reqN_ready and rsp_valid at 0 in every state where this section does not assert them.

Reset
REQ-024 On reset_n=0, SHALL set state IDLE, rr pointer=req0, r=0, and state/data registers to 0; all outputs SHALL be 0.
REQ-025 Reset mid-operation SHALL discard the in-flight operation with no response issued; the first grant after release SHALL go to req0 if it is valid.

Structure
REQ-026 Shared package herculesae_vx_aes_pkg SHALL hold the FSM state enum, the Nr encoding constants and the nr-to-round-count function.
REQ-027 The round-robin grant logic SHALL be the sub-module herculesae_vx_aes_rrarb (2 requesters; inputs valid, advance; output one-hot grant).

Verification
REQ-028 AES-128 encrypt, rk_valid=1, FIPS-197 key 000102..0f, req0_data 00112233445566778899aabbccddeeff -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, 12 cycles after acceptance.
REQ-029 Decrypt 69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> 00112233445566778899aabbccddeeff; rk_idx sequence 10,9,..,0.
REQ-030 req0 and req1 valid continuously -> grants alternate 0,1,0,1; rsp_id matches each grant.
REQ-031 rk_valid low for 3 cycles in round 5 -> dp_valid stays 0 and state holds; result is still correct and latency grows by 3.
REQ-032 rsp_ready low for 5 cycles -> rsp_valid/rsp_data/rsp_id stay stable and both reqN_ready stay 0.
REQ-033 reset_n asserted in round 7 -> all outputs 0 at once, no rsp; after release, req1 alone valid is accepted and completes correctly.
